// File: rtl/i2c_pkg.sv
`default_nettype none
// ------------------------------------------------------------
// i2c_pkg : shared types and defaults for the I2C input stage
// Rev 1.0
// ------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    IDLE    = 2'd1,
    BUSY    = 2'd2
  } bus_state_t;

  localparam int unsigned I2C_FILTER_LEN_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
`default_nettype none
// ------------------------------------------------------------
// i2c_glitch_filter : per-line run-length glitch filter
// Rev 1.0
// ------------------------------------------------------------
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = I2C_FILTER_LEN_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic filt_out
);

  localparam int unsigned     CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Counter saturates implicitly: it is cleared on the flip, before it could reach FILTER_LEN.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (raw_in != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_out = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ------------------------------------------------------------
// i2c_bus_conditioner : filtered SCL/SDA, edge and START/STOP strobes, bus-busy
// Rev 1.0
// ------------------------------------------------------------
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = I2C_FILTER_LEN_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic scl_sync_in,
  input  logic sda_sync_in,
  output logic scl_out,
  output logic sda_out,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);

  logic       scl_filt, sda_filt;
  logic       scl_dly_q, sda_dly_q;
  logic       rise_q, fall_q, start_q, stop_q, busy_q;
  bus_state_t state_q, state_d;
  logic       armed, start_cond, stop_cond;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .raw_in   (scl_sync_in),
    .filt_out (scl_filt)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .raw_in   (sda_sync_in),
    .filt_out (sda_filt)
  );

  // Requiring SCL stable high in both copies suppresses START/STOP when SCL moves in the same cycle.
  always_comb begin
    armed      = (state_q != UNARMED);
    start_cond = ~sda_filt &  sda_dly_q & scl_filt & scl_dly_q;
    stop_cond  =  sda_filt & ~sda_dly_q & scl_filt & scl_dly_q;
    state_d    = state_q;
    case (state_q)
      UNARMED: if (scl_sync_in & sda_sync_in & scl_filt & sda_filt) state_d = IDLE;
      IDLE:    if (start_cond) state_d = BUSY;
      BUSY:    if (stop_cond)  state_d = IDLE;
      default: state_d = UNARMED;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= UNARMED;
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_dly_q <= scl_filt;
      sda_dly_q <= sda_filt;
      rise_q    <= armed &  scl_filt & ~scl_dly_q;
      fall_q    <= armed & ~scl_filt &  scl_dly_q;
      start_q   <= armed & start_cond;
      stop_q    <= armed & stop_cond;
      busy_q    <= (state_d == BUSY);
    end
  end

  assign scl_out   = scl_filt;
  assign sda_out   = sda_filt;
  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign bus_busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Input conditioning stage for the I2C peripheral, directly downstream of the two-flop `d_FlipFlop` synchronizers on SCL and SDA. Consumes the synchronized line levels and applies a per-line digital glitch filter. Produces the filtered levels, single-cycle SCL edge strobes, START/STOP strobes and a bus-busy flag for the protocol FSM.

## Interface
- `FILTER_LEN`, default 4: consecutive cycles a line must disagree with its filtered value before the filtered value changes. Legal range is 1 to 255.
- `clk_in`  input  1  system clock; all state updates on its rising edge.
- `rst_in`  input  1  asynchronous, active-high reset.
- `scl_sync_in`  input  1  synchronized SCL level.
- `sda_sync_in`  input  1  synchronized SDA level.
- `scl_out`  output  1  filtered SCL.
- `sda_out`  output  1  filtered SDA.
- `scl_rise`  output  1  one-cycle strobe: filtered SCL rose.
- `scl_fall`  output  1  one-cycle strobe: filtered SCL fell.
- `start_det`  output  1  one-cycle strobe: START or repeated START.
- `stop_det`  output  1  one-cycle strobe: STOP.
- `bus_busy`  output  1  high between START and STOP.

## Operation
- **Reset values:** `scl_out`=1, `sda_out`=1. All strobes 0. `bus_busy`=0. Filter counters 0. FSM in UNARMED.
- **Filter, per line:**
  - The counter clears on any edge where raw equals filtered.
  - Otherwise the counter increments.
  - When the counter would reach `FILTER_LEN`, the filtered value inverts and the counter clears.
  - `FILTER_LEN`=1 means the filtered value follows raw with one edge of delay.
  - Counter width is $clog2(FILTER_LEN+1). It never wraps.
- **Edge detection:** registered copies `scl_d`, `sda_d` of the filtered values. Strobes are registered from these compares:
  - rise = filt & ~d
  - fall = ~filt & d
  - START = SDA fall while `scl_out` and `scl_d` are both 1.
  - STOP = SDA rise while `scl_out` and `scl_d` are both 1.
- **Simultaneous SCL and SDA filtered change in the same cycle:** no START/STOP. SCL strobes are still produced.
- **FSM states:**
  - UNARMED → IDLE when `scl_sync_in`, `sda_sync_in`, `scl_out`, `sda_out` are all 1 at an edge.
  - IDLE → BUSY on START.
  - BUSY → IDLE on STOP.
  - BUSY on START (repeated START) stays BUSY and pulses `start_det`.
  - STOP in IDLE pulses `stop_det` and stays IDLE.
- **In UNARMED**, all four strobes are forced to 0 and `bus_busy`=0. This prevents a line held low at reset release from producing a spurious START.
- `bus_busy` = (state == BUSY), registered.
- **Reset mid-operation:** all outputs return to reset values immediately, independent of the clock. After release, the block re-arms only on an idle bus.

## Timing
- A raw change present before edge 1 and held produces the filtered change at edge `FILTER_LEN`, so `scl_out`/`sda_out` latency is `FILTER_LEN` edges.
- Strobes and the `bus_busy` transition occur at edge `FILTER_LEN`+1. Total latency is `FILTER_LEN`+1 cycles from the raw change.
- Each strobe is exactly one cycle wide.
- Two edges of the same line are separated by at least `FILTER_LEN` cycles, so strobes for one line are never back-to-back when `FILTER_LEN` ≥ 2.
- No backpressure. Consumers must sample every cycle.

## Structure
- Shared package `i2c_pkg` holds:
  - `bus_state_t` enum {UNARMED, IDLE, BUSY}
  - `I2C_FILTER_LEN_DEFAULT` = 4
- Sub-module `i2c_glitch_filter`:
  - parameter `FILTER_LEN`
  - ports `clk_in`, `rst_in`, `raw_in`, `filt_out`; `filt_out` resets to 1
  - instantiated once for SCL and once for SDA.
- Edge registers, strobe logic and the FSM live in the top module.

## Test plan
1. **Reset, bus idle:** both lines held at 1 across reset release → FSM is IDLE after the first edge; all strobes 0; `bus_busy`=0.
2. **Glitch rejection (`FILTER_LEN`=4):** SDA low for 3 cycles with SCL=1 → `sda_out` stays 1; no `start_det`; state stays IDLE.
3. **START:** SCL=1, SDA driven low and held 10 cycles → `sda_out` falls at edge 4; `start_det` high for one cycle at edge 5; `bus_busy`=1 from edge 5.
4. **Clock toggling and simultaneous change:**
   - SCL toggles with a period of 20 cycles → alternating one-cycle `scl_rise`/`scl_fall`, each 5 cycles after the raw edge.
   - SCL and SDA change on the same cycle → no `start_det`/`stop_det`.
5. **Repeated START, then STOP:**
   - In BUSY, SDA falls with SCL high → `start_det` pulses; `bus_busy` stays 1.
   - Then SDA rises with SCL high → `stop_det` pulses; `bus_busy`=0 at the same edge.
6. **Reset mid-transaction:**
   - `rst_in` asserted in BUSY with SDA low → outputs return to reset values with no clock edge.
   - After release with SDA still low → no strobes; state stays UNARMED until both lines read 1, then IDLE.
